// File: rtl/chiplet_workload_pkg.sv
// Shared definitions for the chiplet workload gather/split blocks.
package chiplet_workload_pkg;

  localparam int unsigned e_merge_replicate = 0;
  localparam int unsigned e_merge_split     = 1;

  typedef enum logic {
    e_collect = 1'b0,
    e_emit    = 1'b1
  } gather_state_e;

  // Sum width wide enough that adding num_in full-scale sizes cannot wrap.
  function automatic int unsigned merge_sum_width(input int unsigned size_w,
                                                  input int unsigned num_in);
    return size_w + $clog2(num_in) + 1;
  endfunction

endpackage

// File: rtl/workload_merge_comb.sv
// Combinational merge of num_in_p {id, size} tokens: max or saturating sum,
// plus an id-mismatch flag against channel 0.
module workload_merge_comb
  import chiplet_workload_pkg::*;
#(
  parameter int unsigned id_width_p      = 4,
  parameter int unsigned size_width_p    = 8,
  parameter int unsigned num_in_p        = 4,
  parameter int unsigned inputs_config_p = e_merge_split,
  localparam int unsigned width_p        = id_width_p + size_width_p
) (
  input  logic [num_in_p-1:0][width_p-1:0] tokens_i,
  output logic [width_p-1:0]               merged_c,
  output logic                             id_mismatch_c,
  output logic                             ovf_c
);

  localparam int unsigned SumW = merge_sum_width(size_width_p, num_in_p);

  typedef struct packed {
    logic [id_width_p-1:0]   id;
    logic [size_width_p-1:0] size;
  } token_t;

  token_t                  tok0;
  token_t                  tok_j;
  logic [size_width_p-1:0] max_size;
  logic [size_width_p-1:0] size_c;
  logic [SumW-1:0]         sum;

  always_comb begin
    tok0          = token_t'(tokens_i[0]);
    tok_j         = tok0;
    max_size      = '0;
    sum           = '0;
    id_mismatch_c = 1'b0;
    for (int unsigned j = 0; j < num_in_p; j++) begin
      tok_j = token_t'(tokens_i[j]);
      if (tok_j.size > max_size) max_size = tok_j.size;
      sum = sum + SumW'(tok_j.size);
      if (tok_j.id != tok0.id) id_mismatch_c = 1'b1;
    end
  end

  // Size selection: replicas take the largest, splits add up and saturate.
  always_comb begin
    ovf_c  = 1'b0;
    size_c = max_size;
    if (inputs_config_p == e_merge_split) begin
      if (sum > SumW'({size_width_p{1'b1}})) begin
        ovf_c  = 1'b1;
        size_c = '1;
      end else begin
        size_c = sum[size_width_p-1:0];
      end
    end
    merged_c = {tok0.id, size_c};
  end

endmodule

// File: rtl/inputs_workload_gather.sv
// Gathers one workload token per input channel, merges them and emits a
// single token downstream; flags id mismatch and size overflow (sticky).
module inputs_workload_gather
  import chiplet_workload_pkg::*;
#(
  parameter int unsigned id_width_p      = 4,
  parameter int unsigned size_width_p    = 8,
  parameter int unsigned num_in_p        = 4,
  parameter int unsigned inputs_config_p = e_merge_split,
  localparam int unsigned width_p        = id_width_p + size_width_p
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_in_p-1:0]              v_i,
  input  logic [num_in_p-1:0][width_p-1:0] data_i,
  output logic [num_in_p-1:0]              ready_o,
  output logic                             v_o,
  output logic [width_p-1:0]               data_o,
  input  logic                             ready_i,
  output logic                             id_err_o,
  output logic                             ovf_o
);

  if (inputs_config_p > e_merge_split) begin : g_bad_config
    $error("inputs_workload_gather: inputs_config_p must be 0 or 1");
  end

  gather_state_e                    state_q, state_d;
  logic [num_in_p-1:0]              full_q, full_d, hs;
  logic [num_in_p-1:0][width_p-1:0] slot_q, slot_d;
  logic [width_p-1:0]               data_q, data_d, merged_c;
  logic                             id_err_q, id_err_d, ovf_q, ovf_d;
  logic                             id_mismatch_c, ovf_c;

  // Ready depends only on registered state; held low while reset is asserted.
  assign ready_o = {num_in_p{reset_n_i & (state_q == e_collect)}} & ~full_q;
  assign hs      = v_i & ready_o;

  // Slot load: merge sees same-edge loads so the last arrival is included.
  always_comb begin
    slot_d = slot_q;
    full_d = full_q | hs;
    for (int unsigned j = 0; j < num_in_p; j++) begin
      if (hs[j]) slot_d[j] = data_i[j];
    end
    if ((state_q == e_emit) && ready_i) full_d = '0;
  end

  workload_merge_comb #(
    .id_width_p     (id_width_p),
    .size_width_p   (size_width_p),
    .num_in_p       (num_in_p),
    .inputs_config_p(inputs_config_p)
  ) u_merge (
    .tokens_i     (slot_d),
    .merged_c     (merged_c),
    .id_mismatch_c(id_mismatch_c),
    .ovf_c        (ovf_c)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_collect;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_collect: if (&full_d) state_d = e_emit;
      e_emit:    if (ready_i) state_d = e_collect;
      default:   state_d = e_collect;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    id_err_d = id_err_q;
    ovf_d    = ovf_q;
    if ((state_q == e_collect) && (&full_d)) begin
      data_d   = merged_c;
      id_err_d = id_err_q | id_mismatch_c;
      ovf_d    = ovf_q | ovf_c;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q   <= '0;
      slot_q   <= '0;
      data_q   <= '0;
      id_err_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      slot_q   <= slot_d;
      data_q   <= data_d;
      id_err_q <= id_err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign v_o      = (state_q == e_emit);
  assign data_o   = data_q;
  assign id_err_o = id_err_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_inputs_workload_gather.sv
// Scoreboard bench: a split-mode and a replicate-mode gather share stimulus;
// a reference model predicts readiness and merged tokens, a monitor compares.
module tb_inputs_workload_gather;

  localparam int unsigned IdW = 4;
  localparam int unsigned SzW = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = IdW + SzW;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N-1:0]          v_i = '0;
  logic [N-1:0][W-1:0]   data_i = '0;
  logic                  ready_i = 1'b0;
  logic [N-1:0]          rdy_s, rdy_r;
  logic                  v_s, v_r, err_s, err_r, ovf_s, ovf_r;
  logic [W-1:0]          d_s, d_r;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t                q_s[$];
  exp_t                q_r[$];
  logic [N-1:0]        gathered = '0;
  bit                  emitting = 1'b0;
  logic [N-1:0][W-1:0] slot = '0;
  bit                  m_err = 1'b0;
  bit                  m_ovf = 1'b0;

  inputs_workload_gather #(
    .id_width_p(IdW), .size_width_p(SzW), .num_in_p(N), .inputs_config_p(1)
  ) u_split (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .ready_o(rdy_s),
    .v_o(v_s), .data_o(d_s), .ready_i(ready_i), .id_err_o(err_s), .ovf_o(ovf_s)
  );

  inputs_workload_gather #(
    .id_width_p(IdW), .size_width_p(SzW), .num_in_p(N), .inputs_config_p(0)
  ) u_repl (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .ready_o(rdy_r),
    .v_o(v_r), .data_o(d_r), .ready_i(ready_i), .id_err_o(err_r), .ovf_o(ovf_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference merge straight from the rules: max or saturating sum, id of ch0.
  function automatic exp_t ref_merge(input bit split, input logic [N-1:0][W-1:0] s);
    exp_t        e;
    int unsigned sum, mx, sz, lim, res;
    lim = (1 << SzW) - 1;
    sum = 0;
    mx  = 0;
    e.err = 1'b0;
    e.ovf = 1'b0;
    e.cyc = cyc;
    for (int j = 0; j < N; j++) begin
      sz  = 32'(s[j][SzW-1:0]);
      sum = sum + sz;
      if (sz > mx) mx = sz;
      if (s[j][W-1:SzW] != s[0][W-1:SzW]) e.err = 1'b1;
    end
    if (split && sum > lim) begin
      e.ovf = 1'b1;
      sum   = lim;
    end
    res    = split ? sum : mx;
    e.data = {s[0][W-1:SzW], SzW'(res)};
    return e;
  endfunction

  // One clock of stimulus: check readiness, advance the model, wait the edge.
  task automatic step();
    logic [N-1:0] exp_rdy, hs;
    exp_t         e;
    @(negedge clk);
    exp_rdy = emitting ? '0 : ~gathered;
    chk("ready_o split", 32'(rdy_s), 32'(exp_rdy));
    chk("ready_o repl", 32'(rdy_r), 32'(exp_rdy));
    hs = v_i & exp_rdy;
    if (!emitting) begin
      for (int j = 0; j < N; j++) if (hs[j]) slot[j] = data_i[j];
      gathered = gathered | hs;
      if (&gathered) begin
        e = ref_merge(1'b1, slot);
        m_err = m_err | e.err;
        m_ovf = m_ovf | e.ovf;
        e.err = m_err;
        e.ovf = m_ovf;
        q_s.push_back(e);
        e = ref_merge(1'b0, slot);
        e.err = m_err;
        e.ovf = 1'b0;
        q_r.push_back(e);
        emitting = 1'b1;
      end
    end else if (ready_i) begin
      emitting = 1'b0;
      gathered = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    v_i     = '0;
    ready_i = 1'b0;
    #1;
    chk("rst v_o", 32'({v_s, v_r}), 0);
    chk("rst data_o", 32'({d_s, d_r}), 0);
    chk("rst flags", 32'({err_s, ovf_s, err_r, ovf_r}), 0);
    chk("rst ready_o", 32'({rdy_s, rdy_r}), 0);
    q_s.delete();
    q_r.delete();
    gathered = '0;
    emitting = 1'b0;
    m_err    = 1'b0;
    m_ovf    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tok(input int j, input int id, input int sz);
    data_i[j] = {IdW'(id), SzW'(sz)};
  endtask

  task automatic all_four(input int i0, input int i1, input int i2, input int i3,
                          input int s0, input int s1, input int s2, input int s3);
    set_tok(0, i0, s0); set_tok(1, i1, s1); set_tok(2, i2, s2); set_tok(3, i3, s3);
    v_i = '1;
    ready_i = 1'b1;
    step();
    v_i = '0;
    repeat (3) step();
  endtask

  task automatic rand_phase(input int cycles, input int err_pct, input int size_max);
    for (int c = 0; c < cycles; c++) begin
      for (int j = 0; j < N; j++)
        set_tok(j, ($urandom_range(0, 99) < err_pct) ? int'($urandom_range(0, 15)) : 5,
                int'($urandom_range(0, size_max)));
      v_i     = N'($urandom);
      ready_i = ($urandom_range(0, 99) < 70);
      step();
    end
  endtask

  task automatic mon(input string nm, input logic v, input logic [W-1:0] d,
                     input logic err, input logic ovf, input exp_t e, output bit pop);
    pop = 1'b0;
    if (e.cyc >= cyc) begin
      chk({nm, " v_o idle"}, 32'(v), 0);
    end else begin
      chk({nm, " v_o"}, 32'(v), 1);
      chk({nm, " data_o"}, 32'(d), 32'(e.data));
      chk({nm, " id_err_o"}, 32'(err), 32'(e.err));
      chk({nm, " ovf_o"}, 32'(ovf), 32'(e.ovf));
      pop = ready_i;
    end
  endtask

  // Monitor: each expected token must be presented the cycle after its gather.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   pop;
    #1;
    if (rst_n) begin
      e.data = '0; e.err = 1'b0; e.ovf = 1'b0; e.cyc = 32'h7fff_ffff;
      if (q_s.size() > 0) e = q_s[0];
      mon("split", v_s, d_s, err_s, ovf_s, e, pop);
      if (pop) void'(q_s.pop_front());
      e.data = '0; e.err = 1'b0; e.ovf = 1'b0; e.cyc = 32'h7fff_ffff;
      if (q_r.size() > 0) e = q_r[0];
      mon("repl", v_r, d_r, err_r, ovf_r, e, pop);
      if (pop) void'(q_r.pop_front());
    end
  end

  initial begin
    #2;
    do_reset();

    all_four(5, 5, 5, 5, 10, 20, 30, 40);

    // Staggered arrival; ch2 keeps v_i high with junk while it waits full.
    for (int j = 0; j < N; j++) set_tok(j, 5, int'($urandom_range(0, 255)));
    ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      v_i = '0;
      if (c == 0) set_tok(2, 5, 3);
      else        set_tok(2, 5, int'($urandom_range(0, 255)));
      if (c <= 8) v_i[2] = 1'b1;
      if (c == 3) begin set_tok(0, 5, 7); v_i[0] = 1'b1; end
      if (c == 7) begin set_tok(1, 5, 9); set_tok(3, 5, 5); v_i[1] = 1'b1; v_i[3] = 1'b1; end
      step();
    end

    rand_phase(200, 0, 63);
    v_i = '0; ready_i = 1'b1;
    repeat (3) step();
    do_reset();

    all_four(5, 5, 5, 5, 200, 100, 0, 0);
    all_four(5, 5, 5, 5, 1, 2, 3, 4);
    all_four(5, 6, 5, 5, 8, 9, 10, 11);
    all_four(5, 5, 5, 5, 1, 1, 1, 1);

    // Back-pressure: hold EMIT with changing junk on the inputs.
    for (int j = 0; j < N; j++) set_tok(j, 3, 16 * j + 1);
    v_i = '1; ready_i = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      for (int j = 0; j < N; j++) set_tok(j, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      step();
    end
    v_i = '0; ready_i = 1'b1;
    repeat (3) step();
    all_four(2, 2, 2, 2, 60, 70, 80, 90);

    rand_phase(300, 5, 255);

    // Reset with two of four slots full, then gather fresh data only.
    do_reset();
    set_tok(0, 7, 111); set_tok(1, 7, 122);
    v_i = 4'b0011; ready_i = 1'b1;
    step();
    do_reset();
    all_four(9, 9, 9, 9, 4, 3, 2, 1);

    v_i = '0; ready_i = 1'b1;
    for (int c = 0; c < 10 && (q_s.size() + q_r.size()) > 0; c++) step();
    chk("drain queues empty", 32'(q_s.size() + q_r.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
